wta_multi: RTL and testbench
============================

# wta_multi

Parametrised winner-take-all stage that generalises the 2-nibble WTA to N channels of W bits each. One N-channel sample is accepted through a valid/ready handshake. The block scans it sequentially, one channel per clock, and presents a one-hot-valued result: winner keeps its value, all other channels are zero. It sits between the current-sample source and downstream spiking/readout logic. Optional hysteresis biases the scan toward the previous winner.

## Interface
- N, 4: channel count, N >= 2
- W, 8: bits per channel
- HYST, 2: hysteresis margin added to previous winner's score; 0 <= HYST <= 2^W-1; used only when WTA_HYST_EN is defined
- clk  in  1  single clock, rising edge
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  sample offered
- in_ready  out  1  block can accept; equals (state == IDLE)
- in_data  in  N*W  channel k at bits [k*W +: W]
- out_valid  out  1  result available
- out_ready  in  1  downstream accepts result
- out_data  out  N*W  winner slot = raw winner value, all other slots 0
- out_idx  out  $clog2(N)  winner channel index
- out_max  out  W  raw winner value

## Operation
- FSM states: IDLE, SCAN, DONE.
- IDLE: in_ready=1. When in_valid, capture in_data into an internal buffer, set best_idx=0 and best_score=eff(0), set cnt=1, then go to SCAN.
- SCAN: each cycle, compare channel cnt. If eff(cnt) >= best_score, channel cnt replaces best; ties go to the higher index. Then cnt increments.
- On the cycle where cnt == N-1, after that compare, load out_data, out_idx and out_max, set out_valid=1, and go to DONE.
- DONE: out_valid=1. Outputs hold stable. When out_ready, clear out_valid and go to IDLE.
- Score width is W+1 bits, unsigned. With the macro undefined, eff(k) = zero-extended value(k). No overflow is possible.
- All channels equal, including all zero: channel N-1 wins.
- Buffered sample is used throughout the scan; in_data may change after the accept.
- out_data, out_idx and out_max keep their last result after the handshake and change only when a new result loads.

## Timing
- Reset: state=IDLE, cnt=0, and all outputs are 0 (out_valid, out_data, out_idx, out_max). in_ready=1 from the first cycle after the reset edge. Hysteresis state is cleared.
- Accept at edge t means out_valid rises after edge t+N-1. Latency is N-1 cycles.
- Earliest next accept: in_ready reasserts the cycle after the out handshake edge. Throughput is one sample per N+1 cycles with no backpressure.
- out_ready is ignored unless out_valid. in_valid is ignored unless in IDLE.
- rst asserted in any state, including mid-SCAN or DONE with out_valid high, aborts the operation. The next cycle matches the reset values above. The partial result is discarded.

## Configuration
- WTA_HYST_EN defined:
  - The block registers prev_idx and prev_vld, updated on each result load.
  - eff(k) = value(k) + HYST when prev_vld and k == prev_idx; otherwise eff(k) = value(k).
  - out_max and out_data always carry raw values.
- WTA_HYST_EN undefined: no hysteresis registers. eff(k) = value(k). HYST is unused.

## Structure
- wta_pkg holds:
  - the state enum (IDLE, SCAN, DONE)
  - default constants for N, W, HYST
  - an IDX_W helper function, $clog2(N)
- One sub-module, wta_score: combinational. Takes value, channel index, prev_idx and prev_vld, and produces the W+1-bit effective score. Instantiated once, on the muxed channel.

## Test plan
All scenarios use N=4, W=8.
- Distinct values: ch0..ch3 = 20,30,50,10; accept at edge t. Expect out_valid after edge t+3, out_idx=2, out_max=50, out_data slot2=50, other slots 0.
- Ties: ch0..ch3 = 40,10,40,40. Expect out_idx=3, out_max=40. All zeros: expect out_idx=3, out_max=0, out_data=0.
- Backpressure: hold out_ready=0 for 5 cycles. Expect out_valid, out_data and out_idx stable and in_ready=0. Then out_ready=1 for one cycle: out_valid=0 and in_ready=1 the next cycle.
- Input change: change in_data the cycle after accept. The result must reflect the captured sample only.
- Reset mid-SCAN: rst pulse 1 cycle after accept. Next cycle: out_valid=0, outputs 0, in_ready=1. No result is ever produced for that sample.
- WTA_HYST_EN, HYST=2: first sample has ch1=50 winning. Second sample ch1=50, ch2=51: expect out_idx=1, out_max=50. Third sample ch1=50, ch2=52: score tie, expect out_idx=2. With the macro undefined, the second sample gives out_idx=2.

Source files
------------

// File: rtl/wta_pkg.sv
// Shared types and defaults for the winner-take-all stage.
// The optional hysteresis feature is selected by the WTA_HYST_EN macro.
package wta_pkg;

  localparam int unsigned WTA_N_DEF    = 4;
  localparam int unsigned WTA_W_DEF    = 8;
  localparam int unsigned WTA_HYST_DEF = 2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SCAN = 2'd1,
    ST_DONE = 2'd2
  } wta_state_e;

  function automatic int unsigned idx_w(input int unsigned n);
    return $clog2(n);
  endfunction

endpackage

// File: rtl/wta_score.sv
// Effective score of one channel: raw value, plus HYST for the previous winner
// when WTA_HYST_EN is defined.
module wta_score
  import wta_pkg::*;
#(
  parameter int unsigned N    = WTA_N_DEF,
  parameter int unsigned W    = WTA_W_DEF,
  parameter int unsigned HYST = WTA_HYST_DEF
) (
  input  logic [W-1:0]        i_value,
  input  logic [idx_w(N)-1:0] i_idx,
  input  logic [idx_w(N)-1:0] i_prev_idx,
  input  logic                i_prev_vld,
  output logic [W:0]          o_score
);

`ifdef WTA_HYST_EN
  logic w_boost;
  assign w_boost = i_prev_vld && (i_idx == i_prev_idx);
  assign o_score = w_boost ? ({1'b0, i_value} + (W+1)'(HYST)) : {1'b0, i_value};
`else
  logic w_unused;
  assign w_unused = ^{i_idx, i_prev_idx, i_prev_vld, (HYST != 0)};
  assign o_score  = {1'b0, i_value};
`endif

endmodule

// File: rtl/wta_multi.sv
// N-channel winner-take-all: captures one sample, scans one channel per clock and
// presents the winner's value in its slot. Hysteresis via WTA_HYST_EN.
module wta_multi
  import wta_pkg::*;
#(
  parameter int unsigned N    = WTA_N_DEF,
  parameter int unsigned W    = WTA_W_DEF,
  parameter int unsigned HYST = WTA_HYST_DEF
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [N*W-1:0]      in_data,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [N*W-1:0]      out_data,
  output logic [idx_w(N)-1:0] out_idx,
  output logic [W-1:0]        out_max
);

  localparam int unsigned IW = idx_w(N);
  localparam logic [IW-1:0] LAST = IW'(N - 1);

  wta_state_e    r_state;
  logic [IW-1:0] r_cnt;
  logic [IW-1:0] r_best_idx;
  logic [W:0]    r_best_score;
  logic [W-1:0]  r_buf [N];
  logic          r_out_valid;
  logic [N*W-1:0] r_out_data;
  logic [IW-1:0] r_out_idx;
  logic [W-1:0]  r_out_max;

  logic [W-1:0]  w_in_ch [N];
  logic          w_idle;
  logic [IW-1:0] w_sel_idx;
  logic [W-1:0]  w_sel_val;
  logic [W:0]    w_score;
  logic          w_take;
  logic [IW-1:0] w_win_idx;
  logic [W-1:0]  w_win_val;
  logic [N*W-1:0] w_out_data;
  logic [IW-1:0] w_prev_idx;
  logic          w_prev_vld;

  for (genvar k = 0; k < N; k++) begin : g_ch
    assign w_in_ch[k] = in_data[k*W +: W];
  end

  // In IDLE the scorer sees channel 0 of the live input so the first best is ready at accept.
  assign w_idle    = (r_state == ST_IDLE);
  assign w_sel_idx = w_idle ? '0 : r_cnt;
  assign w_sel_val = w_idle ? w_in_ch[0] : r_buf[r_cnt];

  wta_score #(
    .N    (N),
    .W    (W),
    .HYST (HYST)
  ) u_score (
    .i_value    (w_sel_val),
    .i_idx      (w_sel_idx),
    .i_prev_idx (w_prev_idx),
    .i_prev_vld (w_prev_vld),
    .o_score    (w_score)
  );

  assign w_take    = (w_score >= r_best_score);
  assign w_win_idx = w_take ? r_cnt : r_best_idx;
  assign w_win_val = r_buf[w_win_idx];

  always_comb begin
    w_out_data = '0;
    for (int k = 0; k < N; k++) begin
      if (IW'(k) == w_win_idx) w_out_data[k*W +: W] = r_buf[k];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_cnt        <= '0;
      r_best_idx   <= '0;
      r_best_score <= '0;
      r_out_valid  <= 1'b0;
      r_out_data   <= '0;
      r_out_idx    <= '0;
      r_out_max    <= '0;
    end else begin
      case (r_state)
        ST_IDLE: if (in_valid) begin
          for (int k = 0; k < N; k++) r_buf[k] <= w_in_ch[k];
          r_best_idx   <= '0;
          r_best_score <= w_score;
          r_cnt        <= IW'(1);
          r_state      <= ST_SCAN;
        end
        ST_SCAN: begin
          r_best_idx <= w_win_idx;
          if (w_take) r_best_score <= w_score;
          r_cnt <= r_cnt + IW'(1);
          if (r_cnt == LAST) begin
            r_cnt       <= '0;
            r_out_valid <= 1'b1;
            r_out_data  <= w_out_data;
            r_out_idx   <= w_win_idx;
            r_out_max   <= w_win_val;
            r_state     <= ST_DONE;
          end
        end
        ST_DONE: if (out_ready) begin
          r_out_valid <= 1'b0;
          r_state     <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

`ifdef WTA_HYST_EN
  logic [IW-1:0] r_prev_idx;
  logic          r_prev_vld;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_prev_idx <= '0;
      r_prev_vld <= 1'b0;
    end else if (r_state == ST_SCAN && r_cnt == LAST) begin
      r_prev_idx <= w_win_idx;
      r_prev_vld <= 1'b1;
    end
  end

  assign w_prev_idx = r_prev_idx;
  assign w_prev_vld = r_prev_vld;
`else
  assign w_prev_idx = '0;
  assign w_prev_vld = 1'b0;
`endif

  assign in_ready  = w_idle;
  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign out_idx   = r_out_idx;
  assign out_max   = r_out_max;

endmodule

// File: tb/tb_wta_multi.sv
// Self-checking bench for wta_multi with N=4, W=8, HYST=2: vector table plus
// hand-written latency, backpressure, input-change and reset-abort sequences.
module tb_wta_multi;

  localparam int N = 4;
  localparam int W = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [N*W-1:0] in_data;
  logic          out_valid;
  logic          out_ready;
  logic [N*W-1:0] out_data;
  logic [1:0]    out_idx;
  logic [W-1:0]  out_max;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  wta_multi #(
    .N    (N),
    .W    (W),
    .HYST (2)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_idx   (out_idx),
    .out_max   (out_max)
  );

  typedef struct {
    logic [31:0] data;
    logic [1:0]  idx;
    logic [7:0]  max;
  } vec_t;

  vec_t q_exp[$];
  vec_t tbl[9];
  vec_t m_e;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] exp_data(input logic [1:0] idx, input logic [7:0] max);
    return 32'(max) << (32'(idx) * 8);
  endfunction

  // Scoreboard: every output handshake must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (q_exp.size() == 0) begin
        check("unexpected_result", 64'(out_idx), 64'hdead);
      end else begin
        m_e = q_exp.pop_front();
        check("sb_idx", 64'(out_idx), 64'(m_e.idx));
        check("sb_max", 64'(out_max), 64'(m_e.max));
        check("sb_data", 64'(out_data), 64'(exp_data(m_e.idx, m_e.max)));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [31:0] d);
    int n = 0;
    while (!in_ready && n < 50) begin
      tick();
      n++;
    end
    if (!in_ready) check("send_timeout", 64'(in_ready), 64'd1);
    in_valid = 1'b1;
    in_data  = d;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (q_exp.size() != 0 && n < 30) begin
      tick();
      n++;
    end
    check("drain_timeout", 64'(q_exp.size()), 64'd0);
    tick();
  endtask

  task automatic run_vec(input vec_t v);
    q_exp.push_back(v);
    send(v.data);
    drain();
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  initial begin
    bit saw_valid;

    // Packed as {ch3, ch2, ch1, ch0}.
    tbl[0] = '{data: {8'd0, 8'd0, 8'd50, 8'd0}, idx: 2'd1, max: 8'd50};
`ifdef WTA_HYST_EN
    tbl[1] = '{data: {8'd0, 8'd51, 8'd50, 8'd0}, idx: 2'd1, max: 8'd50};
`else
    tbl[1] = '{data: {8'd0, 8'd51, 8'd50, 8'd0}, idx: 2'd2, max: 8'd51};
`endif
    tbl[2] = '{data: {8'd0, 8'd52, 8'd50, 8'd0}, idx: 2'd2, max: 8'd52};
    tbl[3] = '{data: {8'd40, 8'd40, 8'd10, 8'd40}, idx: 2'd3, max: 8'd40};
    tbl[4] = '{data: 32'd0, idx: 2'd3, max: 8'd0};
    tbl[5] = '{data: {8'd10, 8'd50, 8'd30, 8'd20}, idx: 2'd2, max: 8'd50};
    tbl[6] = '{data: {8'd3, 8'd2, 8'd1, 8'd255}, idx: 2'd0, max: 8'd255};
    tbl[7] = '{data: {8'd100, 8'd7, 8'd200, 8'd5}, idx: 2'd1, max: 8'd200};
    tbl[8] = '{data: {8'd255, 8'd255, 8'd0, 8'd0}, idx: 2'd3, max: 8'd255};

    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b1;
    tick();
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_out_data", 64'(out_data), 64'd0);
    check("rst_out_idx", 64'(out_idx), 64'd0);
    check("rst_out_max", 64'(out_max), 64'd0);
    rst = 1'b0;
    tick();

    for (int i = 0; i < 9; i++) begin
      // Hysteresis history is cleared before the non-hysteresis vectors.
      if (i == 3) pulse_reset();
      run_vec(tbl[i]);
    end

    // Latency: accept at edge t, out_valid only after edge t+3.
    q_exp.push_back('{data: 32'd0, idx: 2'd2, max: 8'd50});
    in_valid = 1'b1;
    in_data  = {8'd10, 8'd50, 8'd30, 8'd20};
    tick();
    in_valid = 1'b0;
    for (int c = 1; c <= 3; c++) begin
      check("lat_out_valid_low", 64'(out_valid), 64'd0);
      check("lat_in_ready_low", 64'(in_ready), 64'd0);
      tick();
    end
    check("lat_out_valid_high", 64'(out_valid), 64'd1);
    tick();
    check("hs_out_valid_clear", 64'(out_valid), 64'd0);
    check("hs_in_ready_back", 64'(in_ready), 64'd1);
    tick();

    // Backpressure: result held stable while out_ready is low.
    out_ready = 1'b0;
    q_exp.push_back('{data: 32'd0, idx: 2'd0, max: 8'd77});
    send({8'd0, 8'd0, 8'd0, 8'd77});
    for (int c = 0; c < 20 && !out_valid; c++) tick();
    for (int c = 0; c < 5; c++) begin
      check("bp_out_valid", 64'(out_valid), 64'd1);
      check("bp_in_ready", 64'(in_ready), 64'd0);
      check("bp_out_data", 64'(out_data), 64'(exp_data(2'd0, 8'd77)));
      check("bp_out_idx", 64'(out_idx), 64'd0);
      tick();
    end
    out_ready = 1'b1;
    tick();
    check("bp_release_valid", 64'(out_valid), 64'd0);
    check("bp_release_ready", 64'(in_ready), 64'd1);
    check("bp_hold_max", 64'(out_max), 64'd77);
    check("bp_hold_data", 64'(out_data), 64'(exp_data(2'd0, 8'd77)));

    // Input changes right after accept must not affect the result.
    q_exp.push_back('{data: 32'd0, idx: 2'd0, max: 8'd90});
    send({8'd1, 8'd2, 8'd3, 8'd90});
    in_data = {8'd200, 8'd200, 8'd200, 8'd200};
    drain();

    // Reset one cycle after accept aborts the scan.
    send({8'd0, 8'd0, 8'd99, 8'd0});
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("abort_out_valid", 64'(out_valid), 64'd0);
    check("abort_out_data", 64'(out_data), 64'd0);
    check("abort_out_idx", 64'(out_idx), 64'd0);
    check("abort_out_max", 64'(out_max), 64'd0);
    check("abort_in_ready", 64'(in_ready), 64'd1);
    saw_valid = 1'b0;
    for (int c = 0; c < 8; c++) begin
      if (out_valid) saw_valid = 1'b1;
      tick();
    end
    check("abort_no_result", 64'(saw_valid), 64'd0);

    run_vec('{data: {8'd0, 8'd0, 8'd0, 8'd5}, idx: 2'd0, max: 8'd5});

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule
